// File: rtl/ap_ctrl_multi_monitor.sv
// ap_ctrl_multi_monitor: per-channel ap_start/ap_done/ap_continue statistics and protocol-error monitor
// Define MON_SATURATE_EN for saturating txn/busy/stall counters with a sticky overflow bit.
module ap_ctrl_multi_monitor #(
  parameter int N_CH = 4,
  parameter int CNT_W = 32,
  parameter int LAT_W = 16,
  localparam int CH_W = N_CH > 1 ? $clog2(N_CH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             finish,
  input  logic [N_CH-1:0]  ap_start,
  input  logic [N_CH-1:0]  ap_done,
  input  logic [N_CH-1:0]  ap_continue,
  input  logic             rd_en,
  input  logic [CH_W-1:0]  rd_ch,
  input  logic [2:0]       rd_field,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_data,
  output logic [N_CH-1:0]  busy_mask,
  output logic             err_any
);
`ifdef MON_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE_WAIT = 2'd2} state_t;
  localparam logic [LAT_W-1:0] LAT_MAX = '1;
  localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);
  logic [CNT_W-1:0] fld [N_CH];
  logic [N_CH-1:0] act, bad;
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    state_t st;
    logic [LAT_W-1:0] lat_cnt, lat_hold, last_lat, max_lat, lat_now, lat_fin;
    logic [CNT_W-1:0] txn, busy, stall;
    logic err, ovf, s, d, c, t_inc, b_inc, s_inc, t_sat, b_sat, s_sat;
    // The completing cycle of a BUSY transaction counts toward latency, not busy.
    always_comb begin
      {s, d, c} = {ap_start[g], ap_done[g], ap_continue[g]};
      lat_now = lat_cnt == LAT_MAX ? lat_cnt : lat_cnt + LAT_ONE;
      lat_fin = st == IDLE ? LAT_ONE : st == BUSY ? lat_now : lat_hold;
      t_inc = st == DONE_WAIT ? c : (st == BUSY || s) && d && c;
      b_inc = (st == BUSY || (st == IDLE && s)) && !d;
      s_inc = st == DONE_WAIT && !c;
      t_sat = SAT && t_inc && &txn;
      b_sat = SAT && b_inc && &busy;
      s_sat = SAT && s_inc && &stall;
    end
    always_ff @(posedge clock)
      if (reset) begin
        st <= IDLE;
        lat_cnt <= '0;
        lat_hold <= '0;
        last_lat <= '0;
        max_lat <= '0;
        txn <= '0;
        busy <= '0;
        stall <= '0;
        err <= 1'b0;
        ovf <= 1'b0;
      end else if (!finish) begin
        st <= st == DONE_WAIT ? (c ? IDLE : DONE_WAIT)
            : (st == BUSY || s) ? (d ? (c ? IDLE : DONE_WAIT) : BUSY) : IDLE;
        lat_cnt <= st == BUSY ? lat_now : LAT_ONE;
        if (st != DONE_WAIT) lat_hold <= lat_fin;
        if (t_inc) begin
          last_lat <= lat_fin;
          if (lat_fin > max_lat) max_lat <= lat_fin;
        end
        txn <= txn + CNT_W'(t_inc && !t_sat);
        busy <= busy + CNT_W'(b_inc && !b_sat);
        stall <= stall + CNT_W'(s_inc && !s_sat);
        err <= err || (st == IDLE && d && !s);
        ovf <= ovf || t_sat || b_sat || s_sat;
      end
    assign act[g] = st != IDLE;
    assign bad[g] = err || ovf;
    assign fld[g] = rd_field == 3'd0 ? txn
                  : rd_field == 3'd1 ? busy
                  : rd_field == 3'd2 ? stall
                  : rd_field == 3'd3 ? CNT_W'(last_lat)
                  : rd_field == 3'd4 ? CNT_W'(max_lat)
                  : rd_field == 3'd5 ? CNT_W'({ovf, err, st}) : '0;
  end
  always_ff @(posedge clock)
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data <= '0;
      busy_mask <= '0;
      err_any <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= int'(rd_ch) < N_CH ? fld[rd_ch] : '0;
      busy_mask <= act;
      err_any <= |bad;
    end
endmodule

// File: tb/tb_ap_ctrl_multi_monitor.sv
// tb_ap_ctrl_multi_monitor: directed spec scenarios plus random traffic against a timestamp-based model
module tb_ap_ctrl_multi_monitor;
  localparam int N = 5, CW = 8, LW = 6, CMAX = 255, LMAX = 63;
`ifdef MON_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b1, finish = 1'b0, rd_en = 1'b0, rd_valid, err_any;
  logic [N-1:0] ap_start = '0, ap_done = '0, ap_continue = '1, busy_mask;
  logic [2:0] rd_ch = '0, rd_field = '0;
  logic [CW-1:0] rd_data;
  int n_chk = 0, n_fail = 0, cyc = 0;
  int ph [N], t0 [N], lw [N], m_txn [N], m_busy [N], m_stall [N], m_last [N], m_max [N];
  bit m_err [N], m_ovf [N];

  always #5 clock = ~clock;

  ap_ctrl_multi_monitor #(.N_CH(N), .CNT_W(CW), .LAT_W(LW)) dut (
    .clock(clock), .reset(reset), .finish(finish), .ap_start(ap_start), .ap_done(ap_done),
    .ap_continue(ap_continue), .rd_en(rd_en), .rd_ch(rd_ch), .rd_field(rd_field),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy_mask(busy_mask), .err_any(err_any)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int cadd(input int c, input int v);
    if (SAT && v == CMAX) begin
      m_ovf[c] = 1'b1;
      return v;
    end
    return (v + 1) % (CMAX + 1);
  endfunction

  function automatic void complete(input int c, input int lat);
    m_txn[c] = cadd(c, m_txn[c]);
    m_last[c] = lat;
    if (lat > m_max[c]) m_max[c] = lat;
    ph[c] = 0;
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < N; c++) begin
      ph[c] = 0; t0[c] = 0; lw[c] = 0; m_txn[c] = 0; m_busy[c] = 0; m_stall[c] = 0;
      m_last[c] = 0; m_max[c] = 0; m_err[c] = 1'b0; m_ovf[c] = 1'b0;
    end
  endfunction

  // Latency is the inclusive cycle span from start to done, capped at LMAX.
  function automatic void model_step(input logic [N-1:0] s, input logic [N-1:0] d, input logic [N-1:0] k);
    for (int c = 0; c < N; c++) begin
      int lat;
      lat = cyc - t0[c] + 1 > LMAX ? LMAX : cyc - t0[c] + 1;
      if (ph[c] == 0) begin
        if (s[c]) begin
          t0[c] = cyc;
          if (!d[c]) begin ph[c] = 1; m_busy[c] = cadd(c, m_busy[c]); end
          else if (k[c]) complete(c, 1);
          else begin ph[c] = 2; lw[c] = 1; end
        end else if (d[c]) m_err[c] = 1'b1;
      end else if (ph[c] == 1) begin
        if (!d[c]) m_busy[c] = cadd(c, m_busy[c]);
        else if (k[c]) complete(c, lat);
        else begin ph[c] = 2; lw[c] = lat; end
      end else begin
        if (k[c]) complete(c, lw[c]);
        else m_stall[c] = cadd(c, m_stall[c]);
      end
    end
    cyc++;
  endfunction

  function automatic int exp_read(input int ch, input int f);
    if (ch >= N) return 0;
    case (f)
      0: return m_txn[ch];
      1: return m_busy[ch];
      2: return m_stall[ch];
      3: return m_last[ch];
      4: return m_max[ch];
      5: return int'(m_ovf[ch]) * 8 + int'(m_err[ch]) * 4 + ph[ch];
      default: return 0;
    endcase
  endfunction

  task automatic step(input logic [N-1:0] s, input logic [N-1:0] d, input logic [N-1:0] k,
                      input logic f, input logic re, input logic [2:0] ch, input logic [2:0] fl);
    int e_rd, e_mask, e_err;
    ap_start = s; ap_done = d; ap_continue = k; finish = f; rd_en = re; rd_ch = ch; rd_field = fl;
    e_rd = exp_read(int'(ch), int'(fl));
    e_mask = 0;
    e_err = 0;
    for (int c = 0; c < N; c++) begin
      if (ph[c] != 0) e_mask += 1 << c;
      if (m_err[c] || m_ovf[c]) e_err = 1;
    end
    if (!f) model_step(s, d, k);
    @(posedge clock);
    #1;
    check("rd_valid", int'(rd_valid), int'(re));
    if (re) check("rd_data", int'(rd_data), e_rd);
    check("busy_mask", int'(busy_mask), e_mask);
    check("err_any", int'(err_any), e_err);
  endtask

  task automatic peek(input int ch, input int fl, input logic f, input int exp, input string tag);
    step('0, '0, '1, f, 1'b1, 3'(ch), 3'(fl));
    check(tag, int'(rd_data), exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, '1, 1'b0, 1'b0, 3'd0, 3'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1; ap_start = '0; ap_done = '0; ap_continue = '1; finish = 1'b0; rd_en = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_clear();
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_rd_data", int'(rd_data), 0);
    check("rst_busy_mask", int'(busy_mask), 0);
    check("rst_err_any", int'(err_any), 0);
  endtask

  initial begin
    model_clear();
    do_reset();
    step(5'b00001, '0, '1, 1'b0, 1'b0, 3'd0, 3'd0);
    idle(4);
    step('0, 5'b00001, '1, 1'b0, 1'b0, 3'd0, 3'd0);
    peek(0, 0, 1'b0, 1, "t1_txn");
    peek(0, 1, 1'b0, 5, "t1_busy");
    peek(0, 3, 1'b0, 6, "t1_last_lat");
    peek(0, 4, 1'b0, 6, "t1_max_lat");
    peek(0, 2, 1'b0, 0, "t1_stall");
    step(5'b00010, 5'b00010, 5'b11101, 1'b0, 1'b0, 3'd0, 3'd0);
    for (int i = 0; i < 3; i++) step('0, 5'b00010, 5'b11101, 1'b0, 1'b0, 3'd0, 3'd0);
    step('0, '0, '1, 1'b0, 1'b0, 3'd0, 3'd0);
    peek(1, 2, 1'b0, 3, "t2_stall");
    peek(1, 0, 1'b0, 1, "t2_txn");
    peek(1, 5, 1'b0, 0, "t2_status");
    step('0, 5'b00100, '1, 1'b0, 1'b0, 3'd0, 3'd0);
    peek(2, 5, 1'b0, 4, "t3_status");
    check("t3_err_any", int'(err_any), 1);
    peek(2, 0, 1'b0, 0, "t3_txn");
    for (int i = 0; i < 2; i++) step(5'b01000, 5'b01000, '1, 1'b0, 1'b0, 3'd0, 3'd0);
    peek(3, 0, 1'b0, 2, "t4_txn");
    peek(3, 3, 1'b0, 1, "t4_last_lat");
    peek(3, 1, 1'b0, 0, "t4_busy");
    step(5'b00001, '0, '1, 1'b0, 1'b0, 3'd0, 3'd0);
    idle(3);
    peek(0, 1, 1'b0, 9, "t5_busy_pre");
    for (int i = 0; i < 10; i++) peek(0, 1, 1'b1, 10, "t5_busy_frozen");
    step('0, 5'b00001, '1, 1'b0, 1'b0, 3'd0, 3'd0);
    peek(0, 3, 1'b0, 6, "t5_last_lat");
    peek(0, 0, 1'b0, 2, "t5_txn");
    peek(5, 0, 1'b0, 0, "oor_ch5");
    peek(7, 5, 1'b0, 0, "oor_ch7");
    step(5'b00001, '0, '1, 1'b0, 1'b0, 3'd0, 3'd0);
    idle(70);
    step('0, 5'b00001, '1, 1'b0, 1'b0, 3'd0, 3'd0);
    peek(0, 3, 1'b0, LMAX, "lat_sat_last");
    peek(0, 4, 1'b0, LMAX, "lat_sat_max");
    step(5'b00010, '0, '1, 1'b0, 1'b0, 3'd0, 3'd0);
    do_reset();
    peek(1, 5, 1'b0, 0, "rst_mid_status");
    peek(1, 0, 1'b0, 0, "rst_mid_txn");
    for (int i = 0; i < 300; i++) step(5'b10000, 5'b10000, '1, 1'b0, 1'b0, 3'd0, 3'd0);
    peek(4, 0, 1'b0, SAT ? CMAX : 300 % 256, "t6_txn");
    peek(4, 5, 1'b0, SAT ? 8 : 0, "t6_status");
    check("t6_err_any", int'(err_any), SAT ? 1 : 0);
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] s, d, k;
      for (int c = 0; c < N; c++) begin
        s[c] = $urandom_range(0, 3) == 0;
        d[c] = $urandom_range(0, 3) == 0;
        k[c] = $urandom_range(0, 9) < 7;
      end
      if ($urandom_range(0, 499) == 0) do_reset();
      step(s, d, k, $urandom_range(0, 9) == 0, 1'($urandom), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)));
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
